// File: rtl/reg_xfer_sequencer_if.sv
// Command and register-file port bundle for reg_xfer_sequencer.
// The sequencer uses the slave view; the control unit side uses the master view.
interface reg_xfer_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [SEL_W-1:0] cmd_dst;
  logic [SEL_W-1:0] cmd_src;
  logic [WIDTH-1:0] cmd_imm;
  logic             done;
  logic             err;
  logic             busy;
  logic [SEL_W-1:0] rf_s_in;
  logic [SEL_W-1:0] rf_s_out;
  logic [WIDTH-1:0] rf_d_in;
  logic             rf_write_en;
  logic             rf_out_en;
  logic [WIDTH-1:0] rf_d_out;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_d_out,
    output cmd_ready, done, err, busy,
           rf_s_in, rf_s_out, rf_d_in, rf_write_en, rf_out_en
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_d_out,
    input  cmd_ready, done, err, busy,
           rf_s_in, rf_s_out, rf_d_in, rf_write_en, rf_out_en
  );
endinterface

// File: rtl/reg_xfer_sequencer.sv
// Register-transfer micro-sequencer: runs MOV/LDI/INC/DEC against the register
// file as a READ cycle (except LDI) followed by a WRITE cycle.
module reg_xfer_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned NUM_REGS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_xfer_sequencer_if.slave  bus
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [SEL_W-1:0] dst_q;
  logic             cmd_legal_c;
  logic [WIDTH-1:0] read_val_c;

  // Both selects must name a real register; src only matters for MOV.
  always_comb begin
    cmd_legal_c = (32'(bus.cmd_dst) < NUM_REGS) &&
                  ((bus.cmd_op != OP_MOV) || (32'(bus.cmd_src) < NUM_REGS));
  end

  always_comb begin
    read_val_c = bus.rf_d_out;
    case (op_q)
      OP_INC:  read_val_c = bus.rf_d_out + WIDTH'(1);
      OP_DEC:  read_val_c = bus.rf_d_out - WIDTH'(1);
      default: read_val_c = bus.rf_d_out;
    endcase
  end

  // rf_d_in doubles as the temp register: it is loaded exactly when temp would be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      op_q            <= OP_MOV;
      dst_q           <= '0;
      bus.cmd_ready   <= 1'b1;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.rf_s_in     <= '0;
      bus.rf_s_out    <= '0;
      bus.rf_d_in     <= '0;
      bus.rf_write_en <= 1'b0;
      bus.rf_out_en   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (!cmd_legal_c) begin
              bus.err <= 1'b1;
            end else begin
              op_q          <= bus.cmd_op;
              dst_q         <= bus.cmd_dst;
              bus.busy      <= 1'b1;
              bus.cmd_ready <= 1'b0;
              if (bus.cmd_op == OP_LDI) begin
                state           <= ST_WRITE;
                bus.rf_write_en <= 1'b1;
                bus.rf_s_in     <= bus.cmd_dst;
                bus.rf_d_in     <= bus.cmd_imm;
              end else begin
                state         <= ST_READ;
                bus.rf_out_en <= 1'b1;
                bus.rf_s_out  <= (bus.cmd_op == OP_MOV) ? bus.cmd_src : bus.cmd_dst;
              end
            end
          end
        end
        ST_READ: begin
          state           <= ST_WRITE;
          bus.rf_out_en   <= 1'b0;
          bus.rf_write_en <= 1'b1;
          bus.rf_s_in     <= dst_q;
          bus.rf_d_in     <= read_val_c;
        end
        ST_WRITE: begin
          state           <= ST_IDLE;
          bus.rf_write_en <= 1'b0;
          bus.busy        <= 1'b0;
          bus.cmd_ready   <= 1'b1;
          bus.done        <= 1'b1;
        end
        default: begin
          state           <= ST_IDLE;
          bus.rf_write_en <= 1'b0;
          bus.rf_out_en   <= 1'b0;
          bus.busy        <= 1'b0;
          bus.cmd_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Bench for reg_xfer_sequencer: a timeline model predicts every output per cycle
// from each accepted command; a behavioural register file sits on the rf_* bus.
module tb_reg_xfer_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 3;
  localparam int          N     = 4096;

  localparam logic [1:0] MOV = 2'b00;
  localparam logic [1:0] LDI = 2'b01;
  localparam logic [1:0] INC = 2'b10;
  localparam logic [1:0] DEC = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   we_cnt = 0;
  bit   chk_en = 1'b0;

  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] model [8];

  bit               exp_we   [N];
  bit               exp_oe   [N];
  bit               exp_done [N];
  bit               exp_err  [N];
  bit               exp_busy [N];
  logic [SEL_W-1:0] exp_sin  [N];
  logic [SEL_W-1:0] exp_sout [N];
  logic [WIDTH-1:0] exp_din  [N];

  reg_xfer_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  reg_xfer_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .NUM_REGS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file stand-in: captures on write_en, drives d_out only when enabled.
  always @(posedge clk) begin
    if (bus.rf_write_en) regs[bus.rf_s_in] <= bus.rf_d_in;
    if (bus.rf_write_en) we_cnt <= we_cnt + 1;
  end
  assign bus.rf_d_out = bus.rf_out_en ? regs[bus.rf_s_out] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_we"},    32'(bus.rf_write_en), 32'd0);
    chk({tag, "_oe"},    32'(bus.rf_out_en), 32'd0);
    chk({tag, "_sin"},   32'(bus.rf_s_in), 32'd0);
    chk({tag, "_sout"},  32'(bus.rf_s_out), 32'd0);
    chk({tag, "_din"},   32'(bus.rf_d_in), 32'd0);
  endtask

  task automatic clear_expect();
    for (int i = 0; i < N; i++) begin
      exp_we[i] = 0; exp_oe[i] = 0; exp_done[i] = 0; exp_err[i] = 0; exp_busy[i] = 0;
      exp_sin[i] = '0; exp_sout[i] = '0; exp_din[i] = '0;
    end
  endtask

  // Predict the whole command timeline starting from accept edge k.
  task automatic schedule(input int k, input logic [1:0] op, input logic [2:0] dst,
                          input logic [2:0] src, input logic [15:0] imm);
    bit legal;
    int lat;
    logic [15:0] v;
    legal = (dst < 3'd6) && (op != MOV || src < 3'd6);
    if (k + 3 >= N) return;
    if (!legal) begin
      exp_err[k] = 1;
      return;
    end
    lat = (op == LDI) ? 1 : 2;
    case (op)
      LDI:     v = imm;
      MOV:     v = model[src];
      INC:     v = model[dst] + 16'd1;
      default: v = model[dst] - 16'd1;
    endcase
    for (int i = 0; i < lat; i++) exp_busy[k+i] = 1;
    if (op != LDI) begin
      exp_oe[k]   = 1;
      exp_sout[k] = (op == MOV) ? src : dst;
    end
    exp_we[k+lat-1]  = 1;
    exp_sin[k+lat-1] = dst;
    exp_din[k+lat-1] = v;
    exp_done[k+lat]  = 1;
    model[dst] = v;
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [15:0] imm, output int k);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_src   = src;
    bus.cmd_imm   = imm;
    k = 0;
    for (int t = 0; t < 20; t++) begin
      if (bus.cmd_ready) begin
        k = cyc + 1;
        schedule(k, op, dst, src, imm);
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison against the predicted timeline.
  always @(negedge clk) begin
    if (chk_en && rst_n && cyc < N) begin
      chk("bus_excl", 32'(bus.rf_write_en & bus.rf_out_en), 32'd0);
      chk("done_err_excl", 32'(bus.done & bus.err), 32'd0);
      chk("write_en", 32'(bus.rf_write_en), 32'(exp_we[cyc]));
      if (exp_we[cyc]) begin
        chk("s_in", 32'(bus.rf_s_in), 32'(exp_sin[cyc]));
        chk("d_in", 32'(bus.rf_d_in), 32'(exp_din[cyc]));
      end
      chk("out_en", 32'(bus.rf_out_en), 32'(exp_oe[cyc]));
      if (exp_oe[cyc]) chk("s_out", 32'(bus.rf_s_out), 32'(exp_sout[cyc]));
      chk("done", 32'(bus.done), 32'(exp_done[cyc]));
      chk("err", 32'(bus.err), 32'(exp_err[cyc]));
      chk("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!exp_busy[cyc]));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k1, k2, k3, we0;
    for (int i = 0; i < 8; i++) begin regs[i] = '0; model[i] = '0; end
    clear_expect();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_dst = '0; bus.cmd_src = '0; bus.cmd_imm = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Abandon a MOV while it is in its read cycle.
    issue(MOV, 3'd1, 3'd0, 16'h0, k1);
    chk("mid_oe", 32'(bus.rf_out_en), 32'd1);
    we0 = we_cnt;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 32'(we_cnt - we0), 32'd0);
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) model[i] = '0;
    clear_expect();
    chk_en = 1'b1;

    issue(LDI, 3'd0, 3'd0, 16'hAAAA, k1);
    issue(MOV, 3'd1, 3'd0, 16'h0, k2);
    chk("ldi_to_mov_spacing", 32'(k2 - k1), 32'd2);
    idle(4);
    chk("x_after_mov", 32'(regs[1]), 32'h0000AAAA);
    chk("model_x", 32'(model[1]), 32'h0000AAAA);

    issue(LDI, 3'd4, 3'd0, 16'hFFFF, k1);
    issue(INC, 3'd4, 3'd0, 16'h0, k2);
    chk("ldi_to_inc_spacing", 32'(k2 - k1), 32'd2);
    idle(4);
    chk("sp_inc_wrap", 32'(regs[4]), 32'h00000000);
    issue(DEC, 3'd4, 3'd0, 16'h0, k1);
    issue(DEC, 3'd4, 3'd0, 16'h0, k2);
    chk("dec_to_dec_spacing", 32'(k2 - k1), 32'd3);
    issue(INC, 3'd4, 3'd0, 16'h0, k3);
    idle(4);
    chk("sp_dec_wrap", 32'(regs[4]), 32'h0000FFFF);

    issue(MOV, 3'd6, 3'd0, 16'h0, k1);
    idle(2);
    issue(INC, 3'd7, 3'd0, 16'h0, k1);
    issue(MOV, 3'd2, 3'd7, 16'h0, k2);
    chk("err_to_err_spacing", 32'(k2 - k1), 32'd1);
    issue(LDI, 3'd6, 3'd0, 16'h5555, k1);
    idle(3);

    issue(LDI, 3'd2, 3'd0, 16'hCCCC, k1);
    issue(LDI, 3'd5, 3'd0, 16'h1234, k2);
    chk("b2b_ldi_spacing", 32'(k2 - k1), 32'd2);
    idle(3);
    chk("y_val", 32'(regs[2]), 32'h0000CCCC);
    chk("pc_val", 32'(regs[5]), 32'h00001234);

    issue(MOV, 3'd1, 3'd1, 16'h0, k1);
    issue(LDI, 3'd3, 3'd0, 16'hBEEF, k2);
    idle(3);
    chk("x_self_mov", 32'(regs[1]), 32'h0000AAAA);
    chk("fr_full_width", 32'(regs[3]), 32'h0000BEEF);

    for (int n = 0; n < 200; n++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)),
            16'($urandom), k1);
    end
    idle(5);
    for (int r = 0; r < 6; r++) chk($sformatf("final_reg%0d", r), 32'(regs[r]), 32'(model[r]));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/reg_xfer_sequencer.md
Name: reg_xfer_sequencer

Overview:
Micro-sequencer that sits directly upstream of the register file (ACC/X/Y/FR/SP/PC). It accepts one register-transfer command at a time and drives the register file's s_in, s_out, d_in, write_en and out_en ports over one or two cycles. Supported commands are MOV dst<-src, LDI dst<-imm, INC dst and DEC dst, all with 16-bit wrap-around. The control unit uses it to move data, load immediates, and step SP/PC without timing the register file directly.

Parameters:
WIDTH, 16, data width of the register file bus
SEL_W, 3, register select width
NUM_REGS, 6, legal select codes are 0..NUM_REGS-1 (000 ACC, 001 X, 010 Y, 011 FR, 100 SP, 101 PC)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 MOV, 01 LDI, 10 INC, 11 DEC
cmd_dst  input  SEL_W  destination register select
cmd_src  input  SEL_W  source select (MOV only)
cmd_imm  input  WIDTH  immediate (LDI only)
done  output  1  one-cycle pulse: command completed and write committed
err  output  1  one-cycle pulse: command rejected for an illegal select
busy  output  1  high whenever state is not IDLE
rf_s_in  output  SEL_W  to register file s_in
rf_s_out  output  SEL_W  to register file s_out
rf_d_in  output  WIDTH  to register file d_in
rf_write_en  output  1  to register file write_en
rf_out_en  output  1  to register file out_en
rf_d_out  input  WIDTH  from register file tri-state d_out

Behaviour:
- Reset (async, rst_n=0): state IDLE. done=0, err=0, busy=0, cmd_ready=1, rf_write_en=0, rf_out_en=0, rf_s_in=0, rf_s_out=0, rf_d_in=0, temp=0. If reset occurs mid-command, the command is abandoned, no write is issued, and it is not replayed.
- States: IDLE, READ, WRITE.
- cmd_ready=1 only in IDLE. A command is accepted on a rising edge where cmd_valid and cmd_ready are both high. Command fields are captured at acceptance and later input changes are ignored.
- Legality check at acceptance:
  - cmd_dst >= NUM_REGS, or (op=MOV and cmd_src >= NUM_REGS): stay in IDLE, pulse err for the next cycle, no register access.
- Transitions from IDLE on accept:
  - MOV/INC/DEC go to READ.
  - LDI loads temp=cmd_imm and goes directly to WRITE.
- READ (1 cycle):
  - rf_out_en=1. rf_s_out=src for MOV, dst for INC/DEC.
  - At the closing edge: MOV temp=rf_d_out; INC temp=rf_d_out+1; DEC temp=rf_d_out-1, all mod 2^WIDTH (FFFF+1=0000, 0000-1=FFFF). Go to WRITE.
- WRITE (1 cycle):
  - rf_write_en=1, rf_s_in=dst, rf_d_in=temp, rf_out_en=0.
  - The register file captures on the closing edge. Go to IDLE and pulse done for the following cycle.
- Outside their active states, rf_write_en=0 and rf_out_en=0. Select and data outputs hold their last value.
- rf_write_en and rf_out_en are never high in the same cycle, so the tri-state bus is never read during a write.
- Latency from accept edge to done high:
  - MOV/INC/DEC: done is high in the 3rd cycle after accept (accept edge T0, write edge T2, done during T2..T3).
  - LDI: done is high during T1..T2.
- Back-to-back: a new command may be accepted in the same cycle that done is high. No idle bubble is required.
- MOV with src==dst: performs the read and writes back the same value.
- Writes to FR pass all WIDTH bits. Truncation to 4 bits is the register file's responsibility.
- done and err are never high in the same cycle.

Test Plan:
- Reset mid-MOV: assert rst_n=0 while in READ -> all outputs at reset values immediately, no rf_write_en pulse, cmd_ready=1 after release.
- LDI ACC,0xAAAA then MOV X<-ACC -> rf_write_en at s_in=000 with d_in=AAAA; then rf_out_en at s_out=000, rf_write_en at s_in=001 with d_in=AAAA; done for each at the latencies above; register model X=AAAA.
- LDI SP,0xFFFF, INC SP -> SP=0000. Then DEC SP -> SP=FFFF. Each INC/DEC takes 3 cycles to done.
- Illegal select: MOV dst=110 src=000 -> err pulse 1 cycle later, done=0, no rf_write_en or rf_out_en, cmd_ready stays 1.
- Back-to-back: hold cmd_valid with LDI Y,0xCCCC then LDI PC,0x1234 -> second command accepted in the done cycle of the first; writes on consecutive-but-one edges; Y=CCCC, PC=1234.
- Bus exclusion: over a 200-command random legal stream, assert rf_write_en & rf_out_en never both high, and every register value matches a reference model.
